// File: rtl/waitstate_data_memory.sv
// waitstate_data_memory: word-organised data memory with programmable wait states,
// little-endian byte-lane store merge, load sign/zero extension and access-error flagging.
module waitstate_data_memory #(
  parameter int    XLEN        = 32,
  parameter int    ADDR_BITS   = 10,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = "zero.mem"
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_req,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  input  logic [2:0]      i_funct3,
  input  logic            i_read_write,
  output logic            or_mem_ack,
  output logic [XLEN-1:0] or_mem_data,
  output logic            or_mem_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;
  state_t               r_state, w_next;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS+1:0] r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [2:0]           r_f3;
  logic                 r_rw;
  logic [XLEN-1:0]      r_mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] w_idx;
  logic [1:0]           w_lane;
  logic [XLEN-1:0]      w_word, w_shift, w_load, w_lanes, w_merged;
  logic [3:0]           w_be;
  logic                 w_illegal, w_unused;

  initial for (int i = 0; i < 2**ADDR_BITS; i++) r_mem[i] = '0;

  assign w_unused  = &{1'b0, i_mem_addr[XLEN-1:ADDR_BITS+2]};
  assign w_idx     = r_addr[ADDR_BITS+1:2];
  assign w_lane    = r_addr[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_illegal = r_f3 == 3'b011 || r_f3[2:1] == 2'b11 || (r_f3[2] && r_rw) ||
                     (r_f3[1:0] == 2'b01 && w_lane[0]) || (r_f3 == 3'b010 && w_lane != 2'b00);
  // Loads shift the addressed lane down to bit 0, then extend (funct3[2] selects unsigned)
  assign w_shift   = w_word >> {w_lane, 3'b000};
  assign w_load    = r_f3[1:0] == 2'b00 ? {{(XLEN-8){w_shift[7] & ~r_f3[2]}}, w_shift[7:0]} :
                     r_f3[1:0] == 2'b01 ? {{(XLEN-16){w_shift[15] & ~r_f3[2]}}, w_shift[15:0]} :
                     w_shift;
  assign w_be      = r_f3[1:0] == 2'b00 ? 4'b0001 << w_lane :
                     r_f3[1:0] == 2'b01 ? (w_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_lanes   = r_f3[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
                     r_f3[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_merged[8*b +: 8] = w_be[b] ? w_lanes[8*b +: 8] : w_word[8*b +: 8];
  end

  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (i_mem_req ? (WAIT_STATES > 0 ? S_WAIT : S_RESP) : S_IDLE) :
             r_state == S_WAIT ? (r_cnt == 4'd1 ? S_RESP : S_WAIT) :
             r_state == S_RESP ? S_HOLD :
             (i_mem_req ? S_HOLD : S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      or_mem_ack  <= 1'b0;
      or_mem_err  <= 1'b0;
      or_mem_data <= '0;
    end else begin
      r_state    <= w_next;
      or_mem_ack <= r_state == S_RESP;
      if (r_state == S_IDLE && i_mem_req) begin
        r_addr  <= i_mem_addr[ADDR_BITS+1:0];
        r_wdata <= i_mem_data;
        r_f3    <= i_funct3;
        r_rw    <= i_read_write;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_RESP) begin
        or_mem_err  <= w_illegal;
        or_mem_data <= w_illegal ? '0 : r_rw ? w_merged : w_load;
      end
    end
  end

  // The commit is gated by reset so a store landing on a reset edge is dropped
  always @(posedge i_clk) begin
    if (i_rst_n && r_state == S_RESP && r_rw && !w_illegal) r_mem[w_idx] <= w_merged;
  end
endmodule

// File: tb/tb_waitstate_data_memory.sv
// tb_waitstate_data_memory: randomized and directed checks of two memory instances
// (2 and 0 wait states) against a byte-addressed reference model.
module tb_waitstate_data_memory;
  typedef struct packed {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        ee;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n, req0, req1, rw;
  logic [31:0] addr, wdata, rdata0, rdata1;
  logic [2:0]  funct3;
  logic        ack0, ack1, err0, err1;
  logic [7:0]  mb [2][4096];
  int          ws [2] = '{2, 0};
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  waitstate_data_memory #(.XLEN(32), .ADDR_BITS(10), .WAIT_STATES(2), .INIT_FILE("")) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(req0), .i_mem_addr(addr), .i_mem_data(wdata),
    .i_funct3(funct3), .i_read_write(rw), .or_mem_ack(ack0), .or_mem_data(rdata0), .or_mem_err(err0));
  waitstate_data_memory #(.XLEN(32), .ADDR_BITS(10), .WAIT_STATES(0), .INIT_FILE("")) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_req(req1), .i_mem_addr(addr), .i_mem_data(wdata),
    .i_funct3(funct3), .i_read_write(rw), .or_mem_ack(ack1), .or_mem_data(rdata1), .or_mem_err(err1));

  function automatic logic ack_of(input int d);
    return d == 0 ? ack0 : ack1;
  endfunction

  function automatic logic err_of(input int d);
    return d == 0 ? err0 : err1;
  endfunction

  function automatic logic [31:0] data_of(input int d);
    return d == 0 ? rdata0 : rdata1;
  endfunction

  // Reference: memory as a flat byte array; an access of n bytes must be n-aligned
  function automatic void model(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] ed, output logic ee);
    int n, ba, wb;
    logic [31:0] v;
    n  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    ba = int'(a % 4096);
    wb = ba - ba % 4;
    ee = (f == 3'd3) || (f >= 3'd6) || (ba % n != 0) || (f >= 3'd4 && w);
    ed = '0;
    v  = '0;
    if (ee) return;
    if (w) begin
      for (int i = 0; i < n; i++) mb[d][ba + i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) ed[8*i +: 8] = mb[d][wb + i];
    end else begin
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][ba + i];
      if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      ed = v;
    end
  endfunction

  task automatic set_req(input int d, input logic v);
    if (d == 0) req0 = v; else req1 = v;
  endtask

  // One CPU access: lat = edges from capture edge to ack, -1 if no ack within bound
  task automatic xact(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat, output logic after);
    @(negedge clk);
    addr = a; wdata = wd; funct3 = f; rw = w;
    set_req(d, 1'b1);
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (ack_of(d)) begin
        lat = i - 1; rd = data_of(d); er = err_of(d);
      end
      if (i == 1) begin
        addr = $urandom; wdata = $urandom; funct3 = 3'($urandom); rw = 1'($urandom);
      end
    end
    set_req(d, 1'b0);
    @(posedge clk); #1;
    after = ack_of(d);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rw = 1'b0; addr = '0; wdata = '0; funct3 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      total += 3;
      if (ack_of(d) !== 1'b0) $display("FAIL reset_ack dut%0d: got %b want 0", d, ack_of(d)); else passed++;
      if (err_of(d) !== 1'b0) $display("FAIL reset_err dut%0d: got %b want 0", d, err_of(d)); else passed++;
      if (data_of(d) !== 32'h0) $display("FAIL reset_data dut%0d: got %h want 0", d, data_of(d)); else passed++;
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_first_load;
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    xact(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, er, lat, after);
    model(0, 1'b0, 3'd2, 32'h0, 32'h0, ed, ee);
    total += 4;
    if (lat != 3) $display("FAIL first_lat: got %0d want 3", lat); else passed++;
    if (rd !== 32'h0) $display("FAIL first_data: got %h want 0", rd); else passed++;
    if (er !== 1'b0) $display("FAIL first_err: got %b want 0", er); else passed++;
    if (after !== 1'b0) $display("FAIL first_pulse: ack still %b one cycle later", after); else passed++;
  endtask

  task automatic test_extend;
    op_t ops [4];
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    ops = '{'{1'b1, 3'd2, 32'h10, 32'h800000FF, 32'h800000FF, 1'b0},
            '{1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0},
            '{1'b0, 3'd4, 32'h10, 32'h0, 32'h000000FF, 1'b0},
            '{1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFF8000, 1'b0}};
    foreach (ops[i]) begin
      xact(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, rd, er, lat, after);
      model(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, ed, ee);
      total += 3;
      if (rd !== ops[i].exp) $display("FAIL extend_data op%0d: got %h want %h", i, rd, ops[i].exp); else passed++;
      if (er !== ops[i].ee) $display("FAIL extend_err op%0d: got %b want %b", i, er, ops[i].ee); else passed++;
      if (lat != 3) $display("FAIL extend_lat op%0d: got %0d want 3", i, lat); else passed++;
    end
  endtask

  task automatic test_merge;
    op_t ops [5];
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    ops = '{'{1'b1, 3'd2, 32'h20, 32'h11223344, 32'h11223344, 1'b0},
            '{1'b1, 3'd0, 32'h21, 32'hFFFFFFAB, 32'h1122AB44, 1'b0},
            '{1'b0, 3'd2, 32'h20, 32'h0, 32'h1122AB44, 1'b0},
            '{1'b1, 3'd1, 32'h22, 32'h1234BEEF, 32'hBEEFAB44, 1'b0},
            '{1'b0, 3'd2, 32'h20, 32'h0, 32'hBEEFAB44, 1'b0}};
    foreach (ops[i]) begin
      xact(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, rd, er, lat, after);
      model(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, ed, ee);
      total += 2;
      if (rd !== ops[i].exp) $display("FAIL merge_data op%0d: got %h want %h", i, rd, ops[i].exp); else passed++;
      if (er !== ops[i].ee) $display("FAIL merge_err op%0d: got %b want %b", i, er, ops[i].ee); else passed++;
    end
  endtask

  task automatic test_illegal;
    op_t ops [7];
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    ops = '{'{1'b1, 3'd2, 32'h04, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0},
            '{1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 1'b1},
            '{1'b1, 3'd1, 32'h05, 32'h00001234, 32'h0, 1'b1},
            '{1'b0, 3'd3, 32'h04, 32'h0, 32'h0, 1'b1},
            '{1'b1, 3'd4, 32'h04, 32'h00000055, 32'h0, 1'b1},
            '{1'b0, 3'd5, 32'h05, 32'h0, 32'h0, 1'b1},
            '{1'b0, 3'd2, 32'h04, 32'h0, 32'hCAFEF00D, 1'b0}};
    foreach (ops[i]) begin
      xact(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, rd, er, lat, after);
      model(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, ed, ee);
      total += 3;
      if (rd !== ops[i].exp) $display("FAIL illegal_data op%0d: got %h want %h", i, rd, ops[i].exp); else passed++;
      if (er !== ops[i].ee) $display("FAIL illegal_err op%0d: got %b want %b", i, er, ops[i].ee); else passed++;
      if (lat != 3) $display("FAIL illegal_lat op%0d: got %0d want 3", i, lat); else passed++;
    end
  endtask

  task automatic test_alias;
    op_t ops [4];
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    ops = '{'{1'b1, 3'd2, 32'h1000, 32'h13572468, 32'h13572468, 1'b0},
            '{1'b0, 3'd2, 32'h0, 32'h0, 32'h13572468, 1'b0},
            '{1'b0, 3'd2, 32'hFFFFF000, 32'h0, 32'h13572468, 1'b0},
            '{1'b0, 3'd4, 32'h1003, 32'h0, 32'h00000013, 1'b0}};
    foreach (ops[i]) begin
      xact(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, rd, er, lat, after);
      model(0, ops[i].w, ops[i].f, ops[i].a, ops[i].wd, ed, ee);
      total += 1;
      if (rd !== ops[i].exp) $display("FAIL alias_data op%0d: got %h want %h", i, rd, ops[i].exp); else passed++;
    end
  endtask

  task automatic test_hold;
    int lat, extra;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      addr = 32'h10; funct3 = 3'd2; rw = 1'b0;
      set_req(d, 1'b1);
      lat = -1;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
        @(posedge clk); #1;
        if (ack_of(d)) lat = i - 1;
      end
      extra = 0;
      repeat (4) begin
        @(posedge clk); #1;
        extra += int'(ack_of(d));
      end
      total += 2;
      if (lat != ws[d] + 1) $display("FAIL hold_lat dut%0d: got %0d want %0d", d, lat, ws[d] + 1); else passed++;
      if (extra != 0) $display("FAIL hold_extra dut%0d: got %0d extra acks want 0", d, extra); else passed++;
      @(negedge clk) set_req(d, 1'b0);
      @(negedge clk) set_req(d, 1'b1);
      lat = -1;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
        @(posedge clk); #1;
        if (ack_of(d)) lat = i - 1;
      end
      total += 1;
      if (lat != ws[d] + 1) $display("FAIL hold_relaunch dut%0d: got %0d want %0d", d, lat, ws[d] + 1); else passed++;
      @(negedge clk) set_req(d, 1'b0);
      @(posedge clk);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, ed;
    logic er, ee, after;
    int lat;
    xact(0, 1'b1, 3'd2, 32'h30, 32'h5A5A5A5A, rd, er, lat, after);
    model(0, 1'b1, 3'd2, 32'h30, 32'h5A5A5A5A, ed, ee);
    @(negedge clk);
    addr = 32'h30; wdata = 32'hDEADBEEF; funct3 = 3'd2; rw = 1'b1; req0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0;
    @(posedge clk); #1;
    total += 3;
    if (ack0 !== 1'b0) $display("FAIL rstmid_ack: got %b want 0", ack0); else passed++;
    if (err0 !== 1'b0) $display("FAIL rstmid_err: got %b want 0", err0); else passed++;
    if (rdata0 !== 32'h0) $display("FAIL rstmid_data: got %h want 0", rdata0); else passed++;
    @(negedge clk) rst_n = 1'b1;
    xact(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat, after);
    model(0, 1'b0, 3'd2, 32'h30, 32'h0, ed, ee);
    total += 1;
    if (rd !== 32'h5A5A5A5A) $display("FAIL rstmid_keep: got %h want 5a5a5a5a", rd); else passed++;
  endtask

  task automatic test_random;
    logic [31:0] rd, ed, a, wd;
    logic er, ee, after, w;
    logic [2:0] f;
    int lat, d;
    for (int k = 0; k < 160; k++) begin
      d  = k % 2;
      w  = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = $urandom & 32'hFFFFF03F;
      wd = $urandom;
      xact(d, w, f, a, wd, rd, er, lat, after);
      model(d, w, f, a, wd, ed, ee);
      total += 4;
      if (rd !== ed) $display("FAIL rand_data #%0d dut%0d f%0d a=%h: got %h want %h", k, d, f, a, rd, ed); else passed++;
      if (er !== ee) $display("FAIL rand_err #%0d dut%0d f%0d a=%h: got %b want %b", k, d, f, a, er, ee); else passed++;
      if (lat != ws[d] + 1) $display("FAIL rand_lat #%0d dut%0d: got %0d want %0d", k, d, lat, ws[d] + 1); else passed++;
      if (after !== 1'b0) $display("FAIL rand_pulse #%0d dut%0d: ack still %b", k, d, after); else passed++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4096; i++) mb[d][i] = 8'h00;
    test_reset;
    test_first_load;
    test_extend;
    test_merge;
    test_illegal;
    test_alias;
    test_hold;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
